shell_tx_queue: RTL and testbench
=================================

# shell_tx_queue

Byte queue and transmit sequencer between the shell's command/response logic and `UART_TX`. It merges two byte sources into one ordered stream: single echo bytes from the receive path, and multi-byte response messages from the response formatter. Bytes pass through a FIFO and are handed to `UART_TX` one at a time using its DV/Active/Done handshake. This removes the echo/response collision on the transmitter input.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in bytes; must be a power of 2 and ≥ `MSG_MAX`.
- `MSG_MAX`, 13: maximum response message length in bytes.

Ports:
- `CLK` in 1: clock.
- `r_reset` in 1: reset, synchronous, active-high.
- `i_echo_dv` in 1: one-cycle strobe; `i_echo_byte` is valid this cycle.
- `i_echo_byte` in 8: byte to echo.
- `i_msg_start` in 1: one-cycle strobe; capture a message. Honoured only while `o_msg_ready` is 1.
- `i_msg_len` in 4: message length, 0..15. Values above `MSG_MAX` are clamped to `MSG_MAX`.
- `i_msg_bytes` in 8*MSG_MAX: flattened message; byte k is at [8k+7:8k]; byte 0 is sent first.
- `o_msg_ready` out 1: the loader is idle and can accept `i_msg_start`.
- `o_TX_DV` out 1: one-cycle strobe to `UART_TX`.
- `o_TX_Byte` out 8: byte to `UART_TX`; valid when `o_TX_DV` is 1.
- `i_TX_Active` in 1: from `UART_TX`.
- `i_TX_Done` in 1: from `UART_TX`; one-cycle pulse at the end of a frame.
- `o_level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `o_overflow` out 1: one-cycle pulse when an echo byte is dropped.
- `o_busy` out 1: high when the FIFO is non-empty, the loader is active, or the drain FSM is not IDLE.

## Operation
- FIFO write port arbitration:
  - Echo has absolute priority.
  - An echo byte arriving while the FIFO is full is dropped and `o_overflow` pulses for one cycle.
  - Echo bytes are never back-pressured.
- Message loader:
  - On `i_msg_start` with `o_msg_ready` = 1, all `MSG_MAX` bytes and the clamped length are registered.
  - From the next cycle, it writes one byte per cycle in index order.
  - A write stalls (retries the same byte) on any cycle with an echo write or with the FIFO full. Message bytes are never dropped.
  - `o_msg_ready` returns to 1 the cycle after the last byte is written.
  - `i_msg_start` while `o_msg_ready` = 0 is ignored.
  - Length 0: the message is accepted, nothing is written, and `o_msg_ready` stays 1.
- Echo bytes may interleave within a message; relative order within each source is preserved.
- Drain FSM, states IDLE, SEND, WAIT:
  - IDLE → SEND when FIFO non-empty and `i_TX_Active` = 0.
  - SEND:
    - Drive `o_TX_DV` = 1 with `o_TX_Byte` = FIFO head.
    - Pop the FIFO.
    - Go to WAIT.
  - WAIT → IDLE on `i_TX_Done`.
- Simultaneous push and pop: `o_level` is unchanged. A push to a full FIFO in the same cycle as a pop is accepted.
- Pointers wrap modulo `DEPTH`. Full = (`o_level` == `DEPTH`), empty = (`o_level` == 0).
- Reset, including mid-message or mid-frame:
  - FIFO emptied; loader aborted.
  - FSM set to IDLE.
  - A frame already in `UART_TX` is not recalled. The FSM still waits for `i_TX_Active` = 0 before the next send.

## Timing
- Reset values:
  - `o_TX_DV` = 0, `o_TX_Byte` = 0.
  - `o_msg_ready` = 1.
  - `o_level` = 0, `o_overflow` = 0, `o_busy` = 0.
- Echo latency: `i_echo_dv` at cycle N writes at the end of N. With the FSM idle and `i_TX_Active` = 0, SEND is entered at N+1, so `o_TX_DV` = 1 in cycle N+2.
- Message: `i_msg_start` at N gives `o_msg_ready` = 0 from N+1. With no stalls, byte k is written at the end of cycle N+1+k, and `o_msg_ready` = 1 at N+1+len.
- `o_TX_DV` is never high on two consecutive cycles. Between two bytes there is at least one full `UART_TX` frame plus 2 cycles.
- `o_overflow` is registered and pulses in the cycle after the dropped echo.

## Structure
- Shared package `shell_pkg`:
  - `MSG_MAX`.
  - Drain FSM state encodings.
  - ASCII constants CR (8'h0d), LF (8'h0a), BS (8'h08).
- Sub-module `sync_fifo_8`: single-clock byte FIFO with push/pop/full/empty/level, parameter `DEPTH`.
- The loader and drain FSM live in `shell_tx_queue`.

## Test plan
- Reset, then a single echo of 8'h41 with `i_TX_Active` low → `o_TX_DV` high exactly 2 cycles later with `o_TX_Byte` 8'h41; `o_level` returns to 0.
- Message "\nrun\r\n" (len 6) with a `UART_TX` model → bytes 0a 72 75 6e 0d 0a in order; `o_msg_ready` low for exactly 6 cycles.
- Echo 8'h78 on the 3rd loader cycle of a 13-byte message → 8'h78 appears after message byte 1 and before byte 2; loader stalls 1 cycle; all 14 bytes are delivered.
- Hold `i_TX_Active` high and issue 17 echoes with `DEPTH` = 16 → `o_level` = 16; the 17th is dropped with one `o_overflow` pulse; 16 bytes drain afterwards.
- `i_msg_start` with `i_msg_len` = 15 → exactly 13 bytes sent. A second `i_msg_start` during loading is ignored. A len-0 message writes nothing.
- Assert `r_reset` mid-message, after 4 bytes are queued → `o_level` = 0 and `o_msg_ready` = 1 next cycle; no further `o_TX_DV` until new input.

Source files
------------

// File: rtl/shell_pkg.sv
// shell_pkg: constants and drain FSM encodings shared by the shell blocks.
package shell_pkg;
  localparam int MSG_MAX = 13;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} drain_t;
  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] LF = 8'h0a;
  localparam logic [7:0] BS = 8'h08;
endpackage

// File: rtl/sync_fifo_8.sv
// sync_fifo_8: single-clock byte FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo_8 #(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     r_reset,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] level_q;
  logic do_push, do_pop;
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  assign dout_o = mem_q[rp_q];
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end
  always_ff @(posedge CLK) begin
    if (r_reset) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
    end else begin
      wp_q <= do_push ? wp_q + AW'(1) : wp_q;
      rp_q <= do_pop ? rp_q + AW'(1) : rp_q;
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/shell_tx_queue.sv
// shell_tx_queue: merges echo bytes and response messages into one FIFO and feeds UART_TX.
// Echo wins the write port; the message loader retries its current byte whenever it loses.
module shell_tx_queue #(
  parameter int DEPTH = 16,
  parameter int MSG_MAX = shell_pkg::MSG_MAX
) (
  input  logic                   CLK,
  input  logic                   r_reset,
  input  logic                   i_echo_dv,
  input  logic [7:0]             i_echo_byte,
  input  logic                   i_msg_start,
  input  logic [3:0]             i_msg_len,
  input  logic [8*MSG_MAX-1:0]   i_msg_bytes,
  output logic                   o_msg_ready,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow,
  output logic                   o_busy
);
  import shell_pkg::*;
  drain_t state_q, state_d;
  logic full, empty, pop, push, can_push, echo_wr, ld_wr, ld_last, start_ok;
  logic [7:0] push_byte, head;
  logic ld_active_q, ld_active_d, overflow_q;
  logic [3:0] ld_idx_q, ld_idx_d, ld_len_q, ld_len_d, len_c;
  logic [8*MSG_MAX-1:0] ld_bytes_q, ld_bytes_d;

  sync_fifo_8 #(.DEPTH(DEPTH)) u_fifo (
    .CLK(CLK), .r_reset(r_reset), .push_i(push), .din_i(push_byte), .pop_i(pop),
    .dout_o(head), .full_o(full), .empty_o(empty), .level_o(o_level)
  );

  assign can_push = !full || pop;
  assign echo_wr = i_echo_dv && can_push;
  assign ld_wr = ld_active_q && !i_echo_dv && can_push;
  assign push = echo_wr || ld_wr;
  assign push_byte = i_echo_dv ? i_echo_byte : ld_bytes_q[{ld_idx_q, 3'b000} +: 8];
  assign len_c = (i_msg_len > 4'(MSG_MAX)) ? 4'(MSG_MAX) : i_msg_len;
  assign start_ok = !ld_active_q && i_msg_start && len_c != 4'd0;
  assign ld_last = ld_wr && ld_idx_q == ld_len_q - 4'd1;
  assign o_msg_ready = !ld_active_q;
  assign o_overflow = overflow_q;
  assign o_busy = !empty || ld_active_q || state_q != ST_IDLE;

  always_comb begin
    ld_active_d = start_ok || (ld_active_q && !ld_last);
    ld_idx_d = start_ok ? 4'd0 : ld_wr ? ld_idx_q + 4'd1 : ld_idx_q;
    ld_len_d = start_ok ? len_c : ld_len_q;
    ld_bytes_d = (!ld_active_q && i_msg_start) ? i_msg_bytes : ld_bytes_q;
  end

  always_ff @(posedge CLK) begin
    if (r_reset) begin
      ld_active_q <= 1'b0;
      ld_idx_q <= '0;
      ld_len_q <= '0;
      ld_bytes_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ld_active_q <= ld_active_d;
      ld_idx_q <= ld_idx_d;
      ld_len_q <= ld_len_d;
      ld_bytes_q <= ld_bytes_d;
      overflow_q <= i_echo_dv && !can_push;
    end
  end

  always_ff @(posedge CLK) begin
    if (r_reset) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  // A frame left running across reset still blocks the next send via i_TX_Active.
  always_comb begin
    state_d = (state_q == ST_IDLE && !empty && !i_TX_Active) ? ST_SEND :
              (state_q == ST_SEND) ? ST_WAIT :
              (state_q == ST_WAIT && i_TX_Done) ? ST_IDLE : state_q;
  end

  always_comb begin
    o_TX_DV = state_q == ST_SEND;
    pop = o_TX_DV;
    o_TX_Byte = o_TX_DV ? head : 8'h00;
  end
endmodule

// File: tb/tb_shell_tx_queue.sv
// tb_shell_tx_queue: scoreboard bench with a UART_TX model that checks every transmitted byte.
module tb_shell_tx_queue;
  localparam int DEPTH = 16;
  localparam int MSG_MAX = 13;
  localparam int FRAME = 10;
  logic CLK = 0, r_reset = 1;
  logic i_echo_dv = 0, i_msg_start = 0;
  logic [7:0] i_echo_byte = 0;
  logic [3:0] i_msg_len = 0;
  logic [8*MSG_MAX-1:0] i_msg_bytes = '0;
  logic o_msg_ready, o_TX_DV, i_TX_Active, o_overflow, o_busy;
  logic [7:0] o_TX_Byte;
  logic [$clog2(DEPTH):0] o_level;
  logic tx_active_m = 0, tx_done_m = 0, hold_active = 0, prev_dv = 0;
  int frame_cnt = 0, tests = 0, fails = 0, dv_seen = 0;
  logic [7:0] exp_q [$];

  assign i_TX_Active = tx_active_m | hold_active;

  shell_tx_queue #(.DEPTH(DEPTH), .MSG_MAX(MSG_MAX)) dut (
    .CLK(CLK), .r_reset(r_reset), .i_echo_dv(i_echo_dv), .i_echo_byte(i_echo_byte),
    .i_msg_start(i_msg_start), .i_msg_len(i_msg_len), .i_msg_bytes(i_msg_bytes),
    .o_msg_ready(o_msg_ready), .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
    .i_TX_Active(i_TX_Active), .i_TX_Done(tx_done_m), .o_level(o_level),
    .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      tx_done_m = 0;
      if (o_TX_DV) begin
        dv_seen++;
        tests++;
        if (prev_dv) begin fails++; $display("FAIL dv_consecutive got two strobes in a row"); end
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte got %h with nothing expected", o_TX_Byte);
        end else begin
          e = exp_q.pop_front();
          if (o_TX_Byte !== e) begin fails++; $display("FAIL tx_byte got %h exp %h", o_TX_Byte, e); end
        end
        frame_cnt = FRAME;
        tx_active_m = 1;
      end else if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) begin tx_active_m = 0; tx_done_m = 1; end
      end
      prev_dv = o_TX_DV;
    end
  end

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || o_busy || tx_active_m) && n < 3000) begin tick(); n++; end
    tests++;
    if (n >= 3000) begin fails++; $display("FAIL %s_drain_timeout got %0d left exp 0", name, exp_q.size()); end
    tests++;
    if (o_level !== 0) begin fails++; $display("FAIL %s_level_after got %0d exp 0", name, o_level); end
  endtask

  task automatic start_msg(input int len);
    i_msg_len = 4'(len);
    i_msg_start = 1;
  endtask

  task automatic test_reset;
    r_reset = 1;
    repeat (3) tick();
    tests += 6;
    if (o_TX_DV !== 0) begin fails++; $display("FAIL rst_dv got %b exp 0", o_TX_DV); end
    if (o_TX_Byte !== 0) begin fails++; $display("FAIL rst_byte got %h exp 00", o_TX_Byte); end
    if (o_msg_ready !== 1) begin fails++; $display("FAIL rst_ready got %b exp 1", o_msg_ready); end
    if (o_level !== 0) begin fails++; $display("FAIL rst_level got %0d exp 0", o_level); end
    if (o_overflow !== 0) begin fails++; $display("FAIL rst_overflow got %b exp 0", o_overflow); end
    if (o_busy !== 0) begin fails++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    r_reset = 0;
    tick();
  endtask

  task automatic test_echo;
    i_echo_dv = 1;
    i_echo_byte = 8'h41;
    exp_q.push_back(8'h41);
    tick();
    i_echo_dv = 0;
    tests++;
    if (o_TX_DV !== 0) begin fails++; $display("FAIL echo_dv_early got %b exp 0", o_TX_DV); end
    tick();
    tests += 2;
    if (o_TX_DV !== 1) begin fails++; $display("FAIL echo_dv_latency got %b exp 1", o_TX_DV); end
    if (o_TX_Byte !== 8'h41) begin fails++; $display("FAIL echo_byte got %h exp 41", o_TX_Byte); end
    wait_drain("echo");
  endtask

  task automatic test_msg;
    int cnt = 0;
    logic [7:0] m [6] = '{8'h0a, 8'h72, 8'h75, 8'h6e, 8'h0d, 8'h0a};
    i_msg_bytes = '0;
    for (int k = 0; k < 6; k++) begin i_msg_bytes[8*k +: 8] = m[k]; exp_q.push_back(m[k]); end
    start_msg(6);
    for (int i = 0; i < 20; i++) begin
      tick();
      i_msg_start = 0;
      if (!o_msg_ready) cnt++;
    end
    tests++;
    if (cnt != 6) begin fails++; $display("FAIL msg_ready_low got %0d exp 6", cnt); end
    wait_drain("msg");
  endtask

  task automatic test_interleave;
    int cnt = 0;
    for (int k = 0; k < MSG_MAX; k++) begin
      i_msg_bytes[8*k +: 8] = 8'h30 + 8'(k);
      exp_q.push_back(8'h30 + 8'(k));
      if (k == 1) exp_q.push_back(8'h78);
    end
    start_msg(13);
    for (int i = 0; i < 40; i++) begin
      tick();
      i_msg_start = 0;
      i_echo_dv = (i == 2);
      i_echo_byte = 8'h78;
      if (!o_msg_ready) cnt++;
    end
    i_echo_dv = 0;
    tests++;
    if (cnt != 14) begin fails++; $display("FAIL interleave_ready_low got %0d exp 14", cnt); end
    wait_drain("interleave");
  endtask

  task automatic test_overflow;
    int ov = 0;
    hold_active = 1;
    for (int i = 0; i < 17; i++) begin
      i_echo_dv = 1;
      i_echo_byte = 8'h50 + 8'(i);
      if (i < 16) exp_q.push_back(8'h50 + 8'(i));
      tick();
      ov += int'(o_overflow);
    end
    i_echo_dv = 0;
    tests += 2;
    if (o_overflow !== 1) begin fails++; $display("FAIL ovf_pulse_timing got %b exp 1", o_overflow); end
    if (o_level !== 16) begin fails++; $display("FAIL ovf_level got %0d exp 16", o_level); end
    repeat (3) begin tick(); ov += int'(o_overflow); end
    tests++;
    if (ov != 1) begin fails++; $display("FAIL ovf_count got %0d exp 1", ov); end
    hold_active = 0;
    wait_drain("overflow");
  endtask

  task automatic test_clamp;
    int cnt = 0;
    for (int k = 0; k < MSG_MAX; k++) begin
      i_msg_bytes[8*k +: 8] = 8'ha0 + 8'(k);
      exp_q.push_back(8'ha0 + 8'(k));
    end
    start_msg(15);
    for (int i = 0; i < 30; i++) begin
      tick();
      i_msg_start = (i == 3);
      if (i == 3) i_msg_len = 4'd5;
      if (!o_msg_ready) cnt++;
    end
    i_msg_start = 0;
    tests++;
    if (cnt != 13) begin fails++; $display("FAIL clamp_ready_low got %0d exp 13", cnt); end
    wait_drain("clamp");
    dv_seen = 0;
    start_msg(0);
    tick();
    i_msg_start = 0;
    tests += 3;
    if (o_msg_ready !== 1) begin fails++; $display("FAIL len0_ready got %b exp 1", o_msg_ready); end
    if (o_level !== 0) begin fails++; $display("FAIL len0_level got %0d exp 0", o_level); end
    if (o_busy !== 0) begin fails++; $display("FAIL len0_busy got %b exp 0", o_busy); end
    repeat (20) tick();
    tests++;
    if (dv_seen != 0) begin fails++; $display("FAIL len0_sent got %0d exp 0", dv_seen); end
  endtask

  task automatic test_reset_mid;
    hold_active = 1;
    for (int k = 0; k < MSG_MAX; k++) i_msg_bytes[8*k +: 8] = 8'hc0 + 8'(k);
    start_msg(13);
    tick();
    i_msg_start = 0;
    repeat (4) tick();
    tests++;
    if (o_level !== 4) begin fails++; $display("FAIL mid_level_before got %0d exp 4", o_level); end
    r_reset = 1;
    tick();
    r_reset = 0;
    tests += 2;
    if (o_level !== 0) begin fails++; $display("FAIL mid_level_after got %0d exp 0", o_level); end
    if (o_msg_ready !== 1) begin fails++; $display("FAIL mid_ready got %b exp 1", o_msg_ready); end
    hold_active = 0;
    dv_seen = 0;
    repeat (40) tick();
    tests += 2;
    if (dv_seen != 0) begin fails++; $display("FAIL mid_sent got %0d exp 0", dv_seen); end
    if (o_busy !== 0) begin fails++; $display("FAIL mid_busy got %b exp 0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_msg();
    test_interleave();
    test_overflow();
    test_clamp();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
